// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: PC-select encodings, sequencer state type
// and default mult/div occupancy constants.
package pipe_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_EXC = 2'b01;
  localparam logic [1:0] PCSEL_EPC = 2'b10;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Counter must hold DIV_CYC-1; never let the width collapse to zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: loads on md_start, counts down to 0, busy while nonzero.
module md_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int CW = cnt_width(DIV_CYC);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC - 1);

  logic [CW-1:0] md_cnt;

  // A new start always reloads, so a back-to-back op replaces the pending one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline (stage enables, clears, PC select).
// Optional mult/div busy tracking is compiled in with PIPE_CTRL_MD_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       stall_lu,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       md_use_D,
  input  logic       exc_req,
  input  logic       eret_D,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       D_en,
  output logic       clr_D,
  output logic       clr_E,
  output logic       clr_M,
  output logic       md_busy
);

  state_t state;
  logic   stall;
  logic   take_exc;

`ifdef PIPE_CTRL_MD_EN
  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk       (clk),
    .clr_n     (clr_n),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy)
  );

  // HI/LO readers wait both for an op already running and one issuing this cycle.
  assign stall = stall_lu | (md_use_D & (md_busy | md_start));
`else
  logic unused_md;
  assign unused_md = ^{md_start, md_is_div, md_use_D, MULT_CYC[0], DIV_CYC[0]};
  assign md_busy   = 1'b0;
  assign stall     = stall_lu;
`endif

  // M holds a cleared bubble during FLUSH, so a request seen there is spurious.
  assign take_exc = (state == RUN) & exc_req;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= RUN;
    end else begin
      state <= take_exc ? FLUSH : RUN;
    end
  end

  always_comb begin
    pc_en  = 1'b1;
    pc_sel = PCSEL_SEQ;
    D_en   = 1'b1;
    clr_D  = 1'b0;
    clr_E  = 1'b0;
    clr_M  = 1'b0;
    if (take_exc) begin
      pc_sel = PCSEL_EXC;
      D_en   = 1'b0;
      clr_D  = 1'b1;
      clr_E  = 1'b1;
      clr_M  = 1'b1;
    end else if (stall) begin
      pc_en = 1'b0;
      D_en  = 1'b0;
      clr_E = 1'b1;
    end else if (eret_D) begin
      // eret has no delay slot: drop whatever was fetched behind it.
      pc_sel = PCSEL_EPC;
      clr_D  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic,
// compared against a cycle-indexed reference model.
module tb_pipe_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef PIPE_CTRL_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n;
  logic       stall_lu, md_start, md_is_div, md_use_D, exc_req, eret_D;
  logic       pc_en, D_en, clr_D, clr_E, clr_M, md_busy;
  logic [1:0] pc_sel;

  int total  = 0;
  int passed = 0;

  // Model: absolute cycle index, last cycle the md unit is occupied, and the FLUSH cycle.
  int cyc       = 0;
  int busy_last = -1;
  int flush_cyc = -1;

  always #5 clk = ~clk;

  pipe_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .stall_lu  (stall_lu),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_use_D  (md_use_D),
    .exc_req   (exc_req),
    .eret_D    (eret_D),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .D_en      (D_en),
    .clr_D     (clr_D),
    .clr_E     (clr_E),
    .clr_M     (clr_M),
    .md_busy   (md_busy)
  );

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
  endtask

  task automatic check_all(input string tag, input bit e_pc_en, input bit [1:0] e_sel,
                           input bit e_den, input bit e_cd, input bit e_ce, input bit e_cm,
                           input bit e_busy);
    chk({tag, ".pc_en"},   {1'b0, pc_en},   {1'b0, e_pc_en});
    chk({tag, ".pc_sel"},  pc_sel,          e_sel);
    chk({tag, ".D_en"},    {1'b0, D_en},    {1'b0, e_den});
    chk({tag, ".clr_D"},   {1'b0, clr_D},   {1'b0, e_cd});
    chk({tag, ".clr_E"},   {1'b0, clr_E},   {1'b0, e_ce});
    chk({tag, ".clr_M"},   {1'b0, clr_M},   {1'b0, e_cm});
    chk({tag, ".md_busy"}, {1'b0, md_busy}, {1'b0, e_busy});
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance model at next edge.
  task automatic step(input string tag, input bit lu, input bit ms, input bit md,
                      input bit mu, input bit ex, input bit er);
    bit busy, stall, run;
    stall_lu = lu; md_start = ms; md_is_div = md; md_use_D = mu; exc_req = ex; eret_D = er;
    busy  = MD_EN && (cyc <= busy_last);
    stall = lu || (MD_EN && mu && (busy || ms));
    run   = (cyc != flush_cyc);
    @(negedge clk);
    $display("step %-10s cyc=%0d lu=%0b ms=%0b div=%0b use=%0b exc=%0b eret=%0b -> pc_en=%0b sel=%0d D_en=%0b clr=%0b%0b%0b busy=%0b",
             tag, cyc, lu, ms, md, mu, ex, er, pc_en, pc_sel, D_en, clr_D, clr_E, clr_M, md_busy);
    if (run && ex)      check_all(tag, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, busy);
    else if (stall)     check_all(tag, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, busy);
    else if (er)        check_all(tag, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, busy);
    else                check_all(tag, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, busy);
    @(posedge clk);
    if (MD_EN && ms) busy_last = cyc + (md ? DC : MC) - 1;
    if (run && ex)   flush_cyc = cyc + 1;
    cyc++;
    #1;
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases after one edge.
  task automatic do_reset(input string tag);
    stall_lu = 0; md_start = 0; md_is_div = 0; md_use_D = 0; exc_req = 0; eret_D = 0;
    clr_n = 1'b0;
    busy_last = -1;
    flush_cyc = -1;
    #1;
    $display("reset %-10s cyc=%0d -> pc_en=%0b sel=%0d D_en=%0b clr=%0b%0b%0b busy=%0b",
             tag, cyc, pc_en, pc_sel, D_en, clr_D, clr_E, clr_M, md_busy);
    check_all(tag, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    cyc++;
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b1;
    stall_lu = 0; md_start = 0; md_is_div = 0; md_use_D = 0; exc_req = 0; eret_D = 0;
    #2;
    do_reset("por");

    step("idle",     0, 0, 0, 0, 0, 0);
    step("lu",       1, 0, 0, 0, 0, 0);
    step("lu_after", 0, 0, 0, 0, 0, 0);

    // mult issued with a HI/LO reader held in D
    step("mul_c0",   0, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) step($sformatf("mflo_c%0d", i), 0, 0, 0, 1, 0, 0);
    step("mflo_go",  0, 0, 0, 0, 0, 0);

    step("exc_stall", 1, 0, 0, 0, 1, 0);
    step("exc_flush", 0, 0, 0, 0, 1, 0);
    step("exc_again", 0, 0, 0, 0, 1, 0);
    step("flush2",    1, 0, 0, 0, 0, 1);
    step("run",       0, 0, 0, 0, 0, 0);

    step("eret",      0, 0, 0, 0, 0, 1);
    step("eret_lu",   1, 0, 0, 0, 0, 1);
    step("eret_lu2",  1, 0, 0, 0, 0, 1);
    step("eret_go",   0, 0, 0, 0, 0, 1);
    step("exc_eret",  0, 0, 0, 0, 1, 1);
    step("fl_eret",   0, 0, 0, 0, 0, 1);

    // reset three cycles into a divide
    step("div_c0",    0, 1, 1, 0, 0, 0);
    step("div_c1",    0, 0, 0, 0, 0, 0);
    step("div_c2",    0, 0, 0, 0, 0, 0);
    step("div_c3",    0, 0, 0, 1, 0, 0);
    do_reset("mid_div");
    step("post_rst",  0, 0, 0, 1, 0, 0);
    step("post_exc",  0, 0, 0, 0, 1, 0);
    step("post_fl",   0, 0, 0, 0, 0, 0);

    // md_start with reader but no load-use; back-to-back reload div over mult
    step("md_nolu",   0, 1, 0, 1, 0, 0);
    step("md_c1",     0, 0, 0, 1, 0, 0);
    step("md_reload", 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step($sformatf("rl_%0d", i), 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 6) == 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it computes the enable and clear controls for the F/D/E/M stage registers and the PC select for the fetch mux. Its inputs are the decode-stage hazard, the multiply/divide busy state, exceptions raised in M, and `eret` in D. It owns the only multi-cycle state in pipeline control: a mult/div busy counter and a small exception-redirect FSM.

## Interface
Parameters:
- `MULT_CYC`, default 5: cycles a `mult`/`multu` occupies HI/LO.
- `DIV_CYC`, default 10: cycles a `div`/`divu` occupies HI/LO.

Ports:
- `clk` (in, 1): single clock. All state updates on the rising edge.
- `clr_n` (in, 1): reset, asynchronous, active-low.
- `stall_lu` (in, 1): load-use hazard detected in D.
- `md_start` (in, 1): E holds a mult/div starting this cycle.
- `md_is_div` (in, 1): qualifies `md_start`; 1 = div, 0 = mult.
- `md_use_D` (in, 1): D holds an instruction touching HI/LO or the md unit.
- `exc_req` (in, 1): exception or interrupt accepted for the instruction in M.
- `eret_D` (in, 1): D holds `eret`.
- `pc_en` (out, 1): PC register enable.
- `pc_sel` (out, 2): 00 = sequential/branch, 01 = exception vector, 10 = EPC.
- `D_en` (out, 1): F/D register enable.
- `clr_D`, `clr_E`, `clr_M` (out, 1 each): synchronous stage-register clears.
- `md_busy` (out, 1): the md unit is occupied.

## Operation
- `stall = stall_lu | (md_use_D & (md_busy | md_start))`.
- RUN state, `exc_req=0`, `stall=1`:
  - `pc_en=0`, `D_en=0`, `clr_E=1` (bubble into E).
  - `clr_D=0`, `clr_M=0`.
- RUN state, no stall, no exception:
  - `pc_en=1`, `D_en=1`.
  - All clears 0, `pc_sel=00`.
- `eret_D=1` with no stall and no exception:
  - `pc_sel=10`, `pc_en=1`.
  - `clr_D=1`, which kills the slot fetched after `eret` (`eret` has no delay slot).
  - If `stall` is also asserted, the stall wins and `eret` waits in D.
- `exc_req=1` in RUN has the highest priority and overrides stall and `eret`:
  - `clr_D=clr_E=clr_M=1`, `pc_sel=01`, `pc_en=1`, `D_en=0`.
  - Next state is FLUSH.
- FLUSH lasts exactly one cycle:
  - `exc_req` is ignored, because M now holds the cleared bubble.
  - The stall equation still applies, with `clr_E`.
  - Next state is RUN.
- md counter (`md_cnt`):
  - On `md_start`, load `MULT_CYC-1` or `DIV_CYC-1`.
  - Otherwise, decrement while nonzero.
  - `md_busy = (md_cnt != 0)`.
  - `md_start` while busy reloads the counter; the new operation replaces the old one.
  - The counter keeps running across exceptions, since the issued md operation completes architecturally.
- Counter width is `$clog2(DIV_CYC)`, and the counter saturates at 0.

## Timing
- Reset (asynchronous, on `clr_n=0`):
  - State is RUN and `md_cnt=0`.
  - Outputs are `pc_en=1`, `D_en=1`, `pc_sel=00`, all clears 0, `md_busy=0`.
  - Reset may occur mid-count or in FLUSH; both return to RUN with the counter at 0 immediately.
- All control outputs are combinational from the inputs and the registered state, with zero-cycle latency into the same edge.
- `md_start` at edge t gives `md_busy=1` from t+1 through t+`MULT_CYC`-1 (or `DIV_CYC`-1).
  - `md_use_D` is stalled for that whole window, and also in cycle t itself.
- `exc_req` at cycle t: redirect and clears take effect at the edge ending t. Cycle t+1 is FLUSH and cycle t+2 is RUN.

## Configuration
- `PIPE_CTRL_MD_EN` defined: the md counter and `md_busy` are compiled in, as described above.
- `PIPE_CTRL_MD_EN` undefined:
  - The counter is removed and `md_busy` is tied to 0.
  - `md_start`, `md_is_div` and `md_use_D` are ignored.
  - `stall = stall_lu`.

## Structure
- Shared pipeline package holds:
  - the `pc_sel` encodings `PCSEL_SEQ`, `PCSEL_EXC`, `PCSEL_EPC`;
  - the FSM state type `{RUN, FLUSH}`;
  - the default cycle constants.
- One sub-module, `md_busy_cnt`, holds the counter and is instantiated only under `PIPE_CTRL_MD_EN`. The FSM and output logic stay in the top.

## Test plan
- Reset mid-divide: `md_start`/`md_is_div=1`, then `clr_n` low 3 cycles later → `md_busy=0` immediately; state RUN; all outputs at reset values.
- Load-use: `stall_lu=1` for 1 cycle → `pc_en=0`, `D_en=0`, `clr_E=1` that cycle; normal operation the next cycle.
- Mult then `mflo`: `md_start` (mult) at edge 0, `md_use_D=1` held → stall in cycles 0–4; `D_en=1` at cycle 5.
- Exception during stall: `exc_req=1` with `stall_lu=1` → `clr_D/E/M=1`, `pc_sel=01`, `pc_en=1`. A second `exc_req` in the next cycle is ignored (FLUSH); state is RUN one cycle later.
- `eret`: `eret_D=1` without stall → `pc_sel=10`, `clr_D=1`. `eret_D` with `stall_lu` → `pc_sel=00`, `pc_en=0` until the stall clears.
- Macro off: `md_start` plus `md_use_D` with `stall_lu=0` → no stall; `md_busy` stays 0.
